// File: rtl/mem_sync_pkg.sv
// Shared types and constants for the per-bank row-cache sync responder.
package mem_sync_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB_REQ,
    ST_WB_WAIT,
    ST_FE_REQ,
    ST_FE_WAIT,
    ST_SYNC,
    ST_RELEASE
  } state_e;

  localparam logic OP_FETCH = 1'b0;
  localparam logic OP_WB    = 1'b1;

  function automatic int unsigned bank_index(input int unsigned bg,
                                             input int unsigned ba,
                                             input int unsigned bawidth);
    return bg * (32'd1 << bawidth) + ba;
  endfunction

endpackage

// File: rtl/mem_sync_server_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr.
// N must be 2**W so the candidate index wraps by plain W-bit addition.
module rr_arbiter #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && req[ptr + W'(i)]) begin
        any = 1'b1;
        idx = ptr + W'(i);
      end
    end
    grant[idx] = any;
  end

endmodule

// File: rtl/mem_sync_server.sv
// Host-side sync responder: arbitrates bank stalls, issues optional writeback
// then fetch to the host link, and pulses sync back to the granted bank.
module mem_sync_server
  import mem_sync_pkg::*;
#(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int CHWIDTH   = 5,
  parameter int ADDRWIDTH = 17,
  localparam int BANKW    = BGWIDTH + BAWIDTH,
  localparam int NBANKS   = 2 ** BANKW
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NBANKS-1:0]           stall,
  input  logic [NBANKS*ADDRWIDTH-1:0] req_row,
  input  logic [NBANKS*CHWIDTH-1:0]   req_slot,
  input  logic [NBANKS*ADDRWIDTH-1:0] victim_row,
  input  logic [NBANKS-1:0]           victim_dirty,
  output logic [NBANKS-1:0]           sync,
  output logic                        host_cmd_valid,
  input  logic                        host_cmd_ready,
  output logic                        host_cmd_op,
  output logic [BANKW-1:0]            host_cmd_bank,
  output logic [ADDRWIDTH-1:0]        host_cmd_row,
  output logic [CHWIDTH-1:0]          host_cmd_slot,
  input  logic                        host_done,
  output logic                        busy,
  output logic [15:0]                 sync_count
);

  state_e                 state_q, state_d;
  logic [BANKW-1:0]       bank_q, bank_d;
  logic [BANKW-1:0]       rr_q, rr_d;
  logic [ADDRWIDTH-1:0]   req_row_q, req_row_d;
  logic [ADDRWIDTH-1:0]   victim_row_q, victim_row_d;
  logic [CHWIDTH-1:0]     slot_q, slot_d;
  logic [15:0]            sync_count_q, sync_count_d;

  logic [NBANKS-1:0]      arb_grant;
  logic [BANKW-1:0]       arb_idx;
  logic                   arb_any;

  rr_arbiter #(.N(NBANKS), .W(BANKW)) u_arb (
    .req   (stall),
    .ptr   (rr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  always_comb begin
    state_d        = state_q;
    bank_d         = bank_q;
    rr_d           = rr_q;
    req_row_d      = req_row_q;
    victim_row_d   = victim_row_q;
    slot_d         = slot_q;
    sync_count_d   = sync_count_q;
    sync           = '0;
    host_cmd_valid = 1'b0;
    host_cmd_op    = OP_FETCH;
    host_cmd_bank  = '0;
    host_cmd_row   = '0;
    host_cmd_slot  = '0;
    busy           = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          bank_d       = arb_idx;
          req_row_d    = req_row[arb_idx*ADDRWIDTH +: ADDRWIDTH];
          victim_row_d = victim_row[arb_idx*ADDRWIDTH +: ADDRWIDTH];
          slot_d       = req_slot[arb_idx*CHWIDTH +: CHWIDTH];
          rr_d         = arb_idx + BANKW'(1);
          state_d      = (|(victim_dirty & arb_grant)) ? ST_WB_REQ : ST_FE_REQ;
        end
      end
      ST_WB_REQ: begin
        host_cmd_valid = 1'b1;
        host_cmd_op    = OP_WB;
        host_cmd_bank  = bank_q;
        host_cmd_row   = victim_row_q;
        host_cmd_slot  = slot_q;
        if (host_cmd_ready) state_d = ST_WB_WAIT;
      end
      ST_WB_WAIT: if (host_done) state_d = ST_FE_REQ;
      ST_FE_REQ: begin
        host_cmd_valid = 1'b1;
        host_cmd_op    = OP_FETCH;
        host_cmd_bank  = bank_q;
        host_cmd_row   = req_row_q;
        host_cmd_slot  = slot_q;
        if (host_cmd_ready) state_d = ST_FE_WAIT;
      end
      ST_FE_WAIT: if (host_done) state_d = ST_SYNC;
      ST_SYNC: begin
        sync[bank_q] = 1'b1;
        if (sync_count_q != 16'hFFFF) sync_count_d = sync_count_q + 16'd1;
        state_d = ST_RELEASE;
      end
      // Hold off every bank until the served one drops its stall.
      ST_RELEASE: if (!stall[bank_q]) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      bank_q       <= '0;
      rr_q         <= '0;
      req_row_q    <= '0;
      victim_row_q <= '0;
      slot_q       <= '0;
      sync_count_q <= '0;
    end else begin
      state_q      <= state_d;
      bank_q       <= bank_d;
      rr_q         <= rr_d;
      req_row_q    <= req_row_d;
      victim_row_q <= victim_row_d;
      slot_q       <= slot_d;
      sync_count_q <= sync_count_d;
    end
  end

  assign sync_count = sync_count_q;

endmodule

// File: tb/tb_mem_sync_server.sv
// Scoreboard bench for mem_sync_server: expected host commands and sync pulses
// are queued when stimulus is applied and checked as the DUT produces them.
module tb_mem_sync_server;
  import mem_sync_pkg::*;

  localparam int AW = 17;
  localparam int CW = 5;
  localparam int NB = 16;
  localparam int BW = 4;

  typedef struct {
    logic          op;
    int            bank;
    logic [AW-1:0] row;
    logic [CW-1:0] slot;
  } cmd_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NB-1:0]     stall;
  logic [NB*AW-1:0]  req_row;
  logic [NB*CW-1:0]  req_slot;
  logic [NB*AW-1:0]  victim_row;
  logic [NB-1:0]     victim_dirty;
  logic [NB-1:0]     sync;
  logic              host_cmd_valid;
  logic              host_cmd_ready;
  logic              host_cmd_op;
  logic [BW-1:0]     host_cmd_bank;
  logic [AW-1:0]     host_cmd_row;
  logic [CW-1:0]     host_cmd_slot;
  logic              host_done;
  logic              busy;
  logic [15:0]       sync_count;

  mem_sync_server dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .req_row(req_row),
    .req_slot(req_slot), .victim_row(victim_row), .victim_dirty(victim_dirty),
    .sync(sync), .host_cmd_valid(host_cmd_valid), .host_cmd_ready(host_cmd_ready),
    .host_cmd_op(host_cmd_op), .host_cmd_bank(host_cmd_bank),
    .host_cmd_row(host_cmd_row), .host_cmd_slot(host_cmd_slot),
    .host_done(host_done), .busy(busy), .sync_count(sync_count)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   n_acc = 0;
  int   n_sync = 0;
  int   last_sync_cyc = 0;
  int   last_sync_bank = 0;
  int   exp_count = 0;
  bit   acc_pending = 0;
  bit   auto_done = 1;
  cmd_t exp_cmds[$];
  int   exp_syncs[$];

  always @(posedge clk) cyc++;

  // Host model: done pulse one cycle after each accepted command.
  always @(posedge clk) begin
    #1;
    host_done = 1'b0;
    if (acc_pending && auto_done) host_done = 1'b1;
    acc_pending = 0;
  end

  always @(negedge clk) begin
    if (reset_n && host_cmd_valid && host_cmd_ready) begin
      cmd_t c;
      n_acc++;
      acc_pending = 1;
      n_vec++;
      if (exp_cmds.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_cmd: got op=%0b bank=%0d row=%h, none required",
                 host_cmd_op, host_cmd_bank, host_cmd_row);
      end else begin
        c = exp_cmds.pop_front();
        if ({host_cmd_op, host_cmd_bank, host_cmd_row, host_cmd_slot} !==
            {c.op, BW'(c.bank), c.row, c.slot}) begin
          n_err++;
          $display("FAIL cmd: got op=%0b bank=%0d row=%h slot=%0d, required op=%0b bank=%0d row=%h slot=%0d",
                   host_cmd_op, host_cmd_bank, host_cmd_row, host_cmd_slot,
                   c.op, c.bank, c.row, c.slot);
        end
      end
    end
    if (sync !== '0) begin
      n_sync++;
      last_sync_cyc = cyc;
      n_vec++;
      if (exp_syncs.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_sync: got %h, none required", sync);
      end else begin
        last_sync_bank = exp_syncs.pop_front();
        if (sync !== (NB'(1) << last_sync_bank)) begin
          n_err++;
          $display("FAIL sync: got %h, required %h", sync, NB'(1) << last_sync_bank);
        end
      end
    end
  end

  task automatic set_bank(input int b, input logic [AW-1:0] row, input logic [CW-1:0] slot,
                          input logic [AW-1:0] vrow, input logic dirty);
    req_row[b*AW +: AW]    = row;
    req_slot[b*CW +: CW]   = slot;
    victim_row[b*AW +: AW] = vrow;
    victim_dirty[b]        = dirty;
  endtask

  task automatic push_cmd(input logic op, input int b, input logic [AW-1:0] row,
                          input logic [CW-1:0] slot);
    cmd_t c;
    c.op = op; c.bank = b; c.row = row; c.slot = slot;
    exp_cmds.push_back(c);
  endtask

  task automatic push_sync(input int b);
    exp_syncs.push_back(b);
    if (exp_count < 16'hFFFF) exp_count++;
  endtask

  task automatic wait_sync(input int target, input string name);
    int k;
    for (k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (n_sync >= target) break;
    end
    if (k == 60) begin
      n_vec++; n_err++;
      $display("FAIL %s_timeout: got %0d syncs, required %0d", name, n_sync, target);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    stall = '0;
    host_cmd_ready = 1'b1;
    exp_count = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic check_drained(input string name);
    n_vec++;
    if (exp_cmds.size() != 0 || exp_syncs.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: got %0d cmds %0d syncs outstanding, required 0 0",
               name, exp_cmds.size(), exp_syncs.size());
    end
    n_vec++;
    if (sync_count !== 16'(exp_count)) begin
      n_err++;
      $display("FAIL %s_count: got %0d, required %0d", name, sync_count, exp_count);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    n_vec++;
    if ({sync, host_cmd_valid, host_cmd_op, host_cmd_bank, host_cmd_row, host_cmd_slot} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got sync=%h valid=%0b row=%h, required all 0",
               sync, host_cmd_valid, host_cmd_row);
    end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b, required 0", busy); end
    n_vec++;
    if (sync_count !== 16'd0) begin
      n_err++; $display("FAIL reset_count: got %0d, required 0", sync_count);
    end
  endtask

  task automatic test_single_clean();
    int s0;
    int t0;
    set_bank(5, 17'h1ABCD, 5'd3, 17'h0F0F0, 1'b0);
    push_cmd(OP_FETCH, 5, 17'h1ABCD, 5'd3);
    push_sync(5);
    s0 = n_sync;
    @(posedge clk); #1;
    stall[5] = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    set_bank(5, 17'h00001, 5'd9, 17'h00002, 1'b1);
    wait_sync(s0 + 1, "clean");
    n_vec++;
    if (last_sync_cyc - t0 != 3) begin
      n_err++; $display("FAIL clean_latency: got %0d, required 3", last_sync_cyc - t0);
    end
    stall[5] = 1'b0;
    repeat (2) @(posedge clk);
    check_drained("clean");
  endtask

  task automatic test_dirty();
    int s0;
    int a0;
    int t0;
    set_bank(0, 17'h00020, 5'd7, 17'h00010, 1'b1);
    push_cmd(OP_WB, 0, 17'h00010, 5'd7);
    push_cmd(OP_FETCH, 0, 17'h00020, 5'd7);
    push_sync(0);
    s0 = n_sync;
    a0 = n_acc;
    @(posedge clk); #1;
    stall[0] = 1'b1;
    t0 = cyc;
    wait_sync(s0 + 1, "dirty");
    n_vec++;
    if (last_sync_cyc - t0 != 5) begin
      n_err++; $display("FAIL dirty_latency: got %0d, required 5", last_sync_cyc - t0);
    end
    n_vec++;
    if (n_acc - a0 != 2) begin
      n_err++; $display("FAIL dirty_handshakes: got %0d, required 2", n_acc - a0);
    end
    stall[0] = 1'b0;
    repeat (2) @(posedge clk);
    check_drained("dirty");
  endtask

  task automatic test_backpressure();
    int s0;
    int bad;
    set_bank(3, 17'h15555, 5'd21, 17'h0AAAA, 1'b0);
    push_cmd(OP_FETCH, 3, 17'h15555, 5'd21);
    push_sync(3);
    s0 = n_sync;
    @(posedge clk); #1;
    host_cmd_ready = 1'b0;
    stall[3] = 1'b1;
    @(posedge clk); #1;
    set_bank(3, 17'h00003, 5'd1, 17'h00004, 1'b1);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (host_cmd_valid !== 1'b1 || host_cmd_op !== OP_FETCH || host_cmd_bank !== 4'd3 ||
          host_cmd_row !== 17'h15555 || host_cmd_slot !== 5'd21 || busy !== 1'b1)
        bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++; $display("FAIL backpressure_hold: got %0d unstable cycles, required 0", bad);
    end
    n_vec++;
    if (n_acc != 0 && exp_cmds.size() == 0) begin
      n_err++; $display("FAIL backpressure_accept: got early accept, required none");
    end
    @(posedge clk); #1;
    host_cmd_ready = 1'b1;
    wait_sync(s0 + 1, "backpressure");
    stall[3] = 1'b0;
    repeat (2) @(posedge clk);
    check_drained("backpressure");
  endtask

  task automatic serve_in_order(input int n, input string name);
    int s0;
    s0 = n_sync;
    for (int i = 1; i <= n; i++) begin
      wait_sync(s0 + i, name);
      stall[last_sync_bank] = 1'b0;
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_round_robin();
    int b9;
    b9 = int'(bank_index(2, 1, 2));
    apply_reset();
    set_bank(2, 17'h00222, 5'd2, 17'h0, 1'b0);
    set_bank(b9, 17'h00999, 5'd9, 17'h0, 1'b0);
    set_bank(15, 17'h01515, 5'd15, 17'h0, 1'b0);
    set_bank(1, 17'h00111, 5'd1, 17'h0, 1'b0);
    push_cmd(OP_FETCH, 2, 17'h00222, 5'd2);   push_sync(2);
    push_cmd(OP_FETCH, 9, 17'h00999, 5'd9);   push_sync(9);
    push_cmd(OP_FETCH, 15, 17'h01515, 5'd15); push_sync(15);
    @(posedge clk); #1;
    stall[2] = 1'b1; stall[b9] = 1'b1; stall[15] = 1'b1;
    serve_in_order(3, "rr_a");
    check_drained("rr_a");
    push_cmd(OP_FETCH, 1, 17'h00111, 5'd1);   push_sync(1);
    push_cmd(OP_FETCH, 15, 17'h01515, 5'd15); push_sync(15);
    @(posedge clk); #1;
    stall[15] = 1'b1; stall[1] = 1'b1;
    serve_in_order(2, "rr_b");
    check_drained("rr_b");
  endtask

  task automatic test_reset_mid();
    int a0;
    int s0;
    int k;
    set_bank(4, 17'h04444, 5'd4, 17'h0, 1'b0);
    push_cmd(OP_FETCH, 4, 17'h04444, 5'd4);
    auto_done = 0;
    a0 = n_acc;
    @(posedge clk); #1;
    stall[4] = 1'b1;
    for (k = 0; k < 20 && n_acc == a0; k++) @(posedge clk);
    n_vec++;
    if (n_acc == a0) begin
      n_err++; $display("FAIL midreset_accept_timeout: got no accept, required 1");
    end
    @(posedge clk); #1;
    reset_n = 1'b0;
    exp_count = 0;
    @(negedge clk);
    n_vec++;
    if ({sync, host_cmd_valid, host_cmd_row, host_cmd_bank, busy, sync_count} !== '0) begin
      n_err++;
      $display("FAIL midreset_outputs: got sync=%h valid=%0b busy=%0b count=%0d, required all 0",
               sync, host_cmd_valid, busy, sync_count);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    auto_done = 1;
    push_cmd(OP_FETCH, 4, 17'h04444, 5'd4);
    push_sync(4);
    s0 = n_sync;
    wait_sync(s0 + 1, "midreset");
    stall[4] = 1'b0;
    repeat (2) @(posedge clk);
    check_drained("midreset");
  endtask

  task automatic test_stall_held();
    int s0;
    int a0;
    int bad;
    set_bank(7, 17'h07777, 5'd17, 17'h0, 1'b0);
    push_cmd(OP_FETCH, 7, 17'h07777, 5'd17);
    push_sync(7);
    s0 = n_sync;
    @(posedge clk); #1;
    stall[7] = 1'b1;
    wait_sync(s0 + 1, "held");
    a0 = n_acc;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy !== 1'b1 || host_cmd_valid !== 1'b0) bad++;
    end
    n_vec++;
    if (bad != 0 || n_acc != a0 || n_sync != s0 + 1) begin
      n_err++;
      $display("FAIL held_release: got %0d bad cycles, %0d extra cmds, %0d syncs, required 0 0 %0d",
               bad, n_acc - a0, n_sync, s0 + 1);
    end
    @(posedge clk); #1;
    stall[7] = 1'b0;
    @(negedge clk); @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL held_idle: got busy=%0b, required 0", busy); end
    push_cmd(OP_FETCH, 7, 17'h07777, 5'd17);
    push_sync(7);
    @(posedge clk); #1;
    stall[7] = 1'b1;
    wait_sync(s0 + 2, "held_again");
    stall[7] = 1'b0;
    repeat (2) @(posedge clk);
    check_drained("held");
  endtask

  initial begin
    reset_n = 1'b0;
    stall = '0;
    req_row = '0;
    req_slot = '0;
    victim_row = '0;
    victim_dirty = '0;
    host_cmd_ready = 1'b1;
    host_done = 1'b0;
    test_reset();
    test_single_clean();
    test_dirty();
    test_backpressure();
    test_round_robin();
    test_reset_mid();
    test_stall_held();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required summary");
    $fatal(1, "watchdog expired");
  end

endmodule
